// File: rtl/aes_decrypt_sequencer.sv
// aes_decrypt_sequencer: Moore control FSM sequencing key expansion and the AES-128 inverse cipher rounds.
module aes_decrypt_sequencer #(
    parameter int NUM_ROUNDS     = 10,
    parameter int KEY_EXP_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] state_number,
    output logic        mux_enable,
    output logic [1:0]  mux_sel,
    output logic [3:0]  round_key_idx,
    output logic [1:0]  imc_word_sel,
    output logic        imc_word_en,
    output logic        busy,
    output logic        done
);
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_KEYEXP   = 4'd1;
    localparam logic [3:0] S_INIT_ARK = 4'd2;
    localparam logic [3:0] S_R_ISR    = 4'd3;
    localparam logic [3:0] S_R_ISB    = 4'd4;
    localparam logic [3:0] S_R_ARK    = 4'd5;
    localparam logic [3:0] S_R_IMC    = 4'd6;
    localparam logic [3:0] S_F_ISR    = 4'd7;
    localparam logic [3:0] S_F_ISB    = 4'd8;
    localparam logic [3:0] S_F_ARK    = 4'd9;
    localparam logic [3:0] S_DONE     = 4'd11;
    localparam int         CW         = KEY_EXP_CYCLES > 3 ? $clog2(KEY_EXP_CYCLES) : 2;
    localparam logic [3:0] NR         = 4'(NUM_ROUNDS);

    logic [3:0]    r_state, w_next;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [3:0]    r_round, w_round;
    logic [3:0]    r_rk, w_rk;
    logic          w_last_key, w_last_word, w_last_round;

    assign w_last_key   = r_cnt == CW'(KEY_EXP_CYCLES - 1);
    assign w_last_word  = r_cnt[1:0] == 2'd3;
    assign w_last_round = r_round == NR - 4'd1;

    // r_cnt doubles as the key-expansion cycle counter and the InvMixColumns word index
    always_comb begin
        w_next  = r_state;
        w_cnt   = r_cnt;
        w_round = r_round;
        w_rk    = r_rk;
        case (r_state)
            S_IDLE: if (start) begin
                w_next  = S_KEYEXP;
                w_cnt   = '0;
                w_round = 4'd1;
            end
            S_KEYEXP: begin
                w_next = w_last_key ? S_INIT_ARK : S_KEYEXP;
                w_cnt  = w_last_key ? '0 : r_cnt + CW'(1);
                w_rk   = w_last_key ? NR : r_rk;
            end
            S_INIT_ARK: w_next = S_R_ISR;
            S_R_ISR:    w_next = S_R_ISB;
            S_R_ISB: begin
                w_next = S_R_ARK;
                w_rk   = NR - r_round;
            end
            S_R_ARK: begin
                w_next = S_R_IMC;
                w_cnt  = '0;
            end
            S_R_IMC: begin
                w_next  = !w_last_word ? S_R_IMC : w_last_round ? S_F_ISR : S_R_ISR;
                w_cnt   = w_last_word ? '0 : r_cnt + CW'(1);
                w_round = w_last_word && !w_last_round ? r_round + 4'd1 : r_round;
            end
            S_F_ISR: w_next = S_F_ISB;
            S_F_ISB: begin
                w_next = S_F_ARK;
                w_rk   = 4'd0;
            end
            S_F_ARK: w_next = S_DONE;
            S_DONE:  w_next = start ? S_DONE : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_round <= 4'd1;
            r_rk    <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            r_round <= w_round;
            r_rk    <= w_rk;
        end
    end

    assign state_number  = 32'(r_state);
    assign imc_word_en   = r_state == S_R_IMC;
    assign imc_word_sel  = imc_word_en ? r_cnt[1:0] : 2'd0;
    assign mux_sel       = (r_state == S_R_ISR || r_state == S_F_ISR) ? 2'd1 :
                           (r_state == S_R_ISB || r_state == S_F_ISB) ? 2'd2 :
                           imc_word_en ? 2'd3 : 2'd0;
    assign mux_enable    = (r_state inside {S_INIT_ARK, S_R_ISR, S_R_ISB, S_R_ARK, S_F_ISR, S_F_ISB, S_F_ARK})
                           || (imc_word_en && w_last_word);
    assign round_key_idx = r_rk;
    assign busy          = r_state != S_IDLE && r_state != S_DONE;
    assign done          = r_state == S_DONE;
endmodule

// File: tb/tb_aes_decrypt_sequencer.sv
// tb_aes_decrypt_sequencer: randomized runs checked cycle by cycle against an expected-trace model.
module tb_aes_decrypt_sequencer;
    localparam int NR = 10;
    localparam int KE = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] state_number;
    logic        mux_enable;
    logic [1:0]  mux_sel;
    logic [3:0]  round_key_idx;
    logic [1:0]  imc_word_sel;
    logic        imc_word_en;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [31:0] sn;
        logic        me;
        logic [1:0]  ms;
        logic [3:0]  rk;
        logic [1:0]  ws;
        logic        we;
        logic        busy;
        logic        done;
    } obs_t;

    obs_t w_obs;
    obs_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_rk   = 0;

    aes_decrypt_sequencer #(.NUM_ROUNDS(NR), .KEY_EXP_CYCLES(KE)) dut (
        .clk(clk), .reset(reset), .start(start), .state_number(state_number),
        .mux_enable(mux_enable), .mux_sel(mux_sel), .round_key_idx(round_key_idx),
        .imc_word_sel(imc_word_sel), .imc_word_en(imc_word_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign w_obs = {state_number, mux_enable, mux_sel, round_key_idx, imc_word_sel, imc_word_en, busy, done};

    function automatic obs_t mk(int sn, bit me, int ms, int ws, bit we, bit bz, bit dn);
        obs_t o;
        o.sn   = 32'(sn);
        o.me   = me;
        o.ms   = 2'(ms);
        o.rk   = 4'(m_rk);
        o.ws   = 2'(ws);
        o.we   = we;
        o.busy = bz;
        o.done = dn;
        return o;
    endfunction

    // Expected per-cycle outputs of one full decryption, from the start-sample edge onward
    task automatic build_run();
        q.delete();
        for (int k = 0; k < KE; k++) q.push_back(mk(1, 0, 0, 0, 0, 1, 0));
        m_rk = NR;
        q.push_back(mk(2, 1, 0, 0, 0, 1, 0));
        for (int r = 1; r < NR; r++) begin
            q.push_back(mk(3, 1, 1, 0, 0, 1, 0));
            q.push_back(mk(4, 1, 2, 0, 0, 1, 0));
            m_rk = NR - r;
            q.push_back(mk(5, 1, 0, 0, 0, 1, 0));
            for (int w = 0; w < 4; w++) q.push_back(mk(6, w == 3, 3, w, 1, 1, 0));
        end
        q.push_back(mk(7, 1, 1, 0, 0, 1, 0));
        q.push_back(mk(8, 1, 2, 0, 0, 1, 0));
        m_rk = 0;
        q.push_back(mk(9, 1, 0, 0, 0, 1, 0));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input obs_t e);
        checks++;
        assert (w_obs === e) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, w_obs, e);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_run(input int abort_at, input int done_hold, input int gap);
        int pulses = 0;
        int imcs = 0;
        int cyc = 0;
        int first_done = -1;
        int rks[$];
        for (int g = 0; g < gap; g++) begin
            start = 1'b0;
            step();
            chk("idle_gap", mk(0, 0, 0, 0, 0, 0, 0));
        end
        build_run();
        start = 1'b1;
        step();
        for (int i = 0; i < q.size(); i++) begin
            cyc++;
            chk($sformatf("run[%0d]", i), q[i]);
            if (mux_enable) pulses++;
            if (mux_enable && mux_sel == 2'd0) rks.push_back(int'(round_key_idx));
            if (imc_word_en && imc_word_sel == 2'd3) imcs++;
            if (i == abort_at) begin
                reset = 1'b1;
                start = 1'b0;
                step();
                m_rk = 0;
                chk("after_reset", mk(0, 0, 0, 0, 0, 0, 0));
                reset = 1'b0;
                return;
            end
            start = i == q.size() - 1 ? 1'b1 : 1'($urandom_range(0, 1));
            step();
        end
        for (int j = 0; j <= done_hold; j++) begin
            cyc++;
            if (done && first_done < 0) first_done = cyc;
            chk("done_hold", mk(11, 0, 0, 0, 0, 0, 1));
            start = j < done_hold;
            step();
        end
        chk("exit_idle", mk(0, 0, 0, 0, 0, 0, 0));
        chk_int("done_latency", first_done, KE + 5 + 7 * (NR - 1));
        chk_int("enable_pulses", pulses, 1 + 4 * (NR - 1) + 3);
        chk_int("imc_phases", imcs, NR - 1);
        chk_int("rk_count", rks.size(), NR + 1);
        for (int k = 0; k < rks.size() && k <= NR; k++) chk_int($sformatf("rk_order[%0d]", k), rks[k], NR - k);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        repeat (3) step();
        chk("reset_state", mk(0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle", mk(0, 0, 0, 0, 0, 0, 0));
        end
        do_run(-1, 5, 1);
        do_run(-1, int'($urandom_range(0, 5)), 2);
        do_run(KE + 1 + 7 * 4 + 5, 0, 1);
        do_run(-1, 2, 1);
        for (int k = 0; k < 4; k++)
            do_run($urandom_range(0, 1) == 1 ? int'($urandom_range(0, 76)) : -1,
                   int'($urandom_range(0, 4)), int'($urandom_range(1, 4)));
        do_run(-1, 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes_decrypt_sequencer.md
Name: aes_decrypt_sequencer

Overview:
Control FSM for the AES-128 decryption datapath. It drives the state register's round-state number and write enable, the operation-select mux, the round-key index and the InvMixColumns word counter. It sequences key expansion, the initial AddRoundKey, the middle rounds and the final round. It handshakes with the software interface through a start/done pair.

Parameters:
NUM_ROUNDS, 10, total AES rounds (AES-128); middle rounds = NUM_ROUNDS-1
KEY_EXP_CYCLES, 10, cycles spent in key-expansion phase (state_number==1)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  level request from software; sampled in IDLE and DONE
state_number  output  32 (integer)  phase code to state register: 0 idle/clear, 1 key-exp/load msg, 2..10 ops, 11 done/hold
mux_enable  output  1  state register write strobe for the current op result
mux_sel  output  2  op select: 0 AddRoundKey, 1 InvShiftRows, 2 InvSubBytes, 3 InvMixColumns
round_key_idx  output  4  round key index for AddRoundKey
imc_word_sel  output  2  32-bit column selected for InvMixColumns
imc_word_en  output  1  capture strobe for the current InvMixColumns column
busy  output  1  high in any state other than IDLE and DONE
done  output  1  high in DONE

Behaviour:
- States and state_number codes:
  - IDLE 0
  - KEYEXP 1
  - INIT_ARK 2
  - R_ISR 3, R_ISB 4, R_ARK 5, R_IMC 6
  - F_ISR 7, F_ISB 8, F_ARK 9
  - DONE 11 (code 10 unused)
- Reset: state IDLE, round counter 1, all counters 0; every output 0 (state_number 0, round_key_idx 0).
- IDLE: start=1 -> KEYEXP next cycle; otherwise stay.
- KEYEXP:
  - held exactly KEY_EXP_CYCLES cycles (cycle counter 0..KEY_EXP_CYCLES-1), then INIT_ARK.
  - mux_enable=0 throughout; the state register loads the message from state_number==1.
- INIT_ARK: 1 cycle; mux_sel=0, round_key_idx=NUM_ROUNDS, mux_enable=1. Then R_ISR with round r=1.
- Middle round r (1..NUM_ROUNDS-1):
  - R_ISR: 1 cycle, mux_sel=1, enable=1.
  - R_ISB: 1 cycle, mux_sel=2, enable=1.
  - R_ARK: 1 cycle, mux_sel=0, round_key_idx=NUM_ROUNDS-r, enable=1.
  - R_IMC: 4 cycles, mux_sel=3, imc_word_sel=0,1,2,3, imc_word_en=1 each cycle; mux_enable=1 only on the imc_word_sel=3 cycle.
  - After R_IMC: r<NUM_ROUNDS-1 -> r+1, R_ISR; else F_ISR.
- Final round:
  - F_ISR: mux_sel=1; F_ISB: mux_sel=2; F_ARK: mux_sel=0, round_key_idx=0.
  - Each is 1 cycle with enable=1. Then DONE.
- DONE:
  - done=1, busy=0, mux_enable=0; state register holds the result.
  - Stays while start=1; start=0 -> IDLE (the register is cleared).
- Outputs are registered from state (Moore). Outside its phase, round_key_idx keeps its last value; imc_word_sel/en are 0 outside R_IMC.
- Latency: start sampled at edge t:
  - state_number=1 for cycles t+1..t+K (K=KEY_EXP_CYCLES).
  - INIT_ARK at t+K+1.
  - Middle rounds take 7*(NUM_ROUNDS-1) cycles.
  - Final round takes 3 cycles.
  - done first high at t+K+5+7*(NUM_ROUNDS-1), i.e. t+78 for defaults.
- Count of mux_enable pulses per run = 1 + 4*(NUM_ROUNDS-1) + 3 = 40 for defaults.
- start deasserted while busy: ignored, run completes; DONE then exits to IDLE on the next cycle.
- start held high through DONE: no restart until start falls and rises again via IDLE.
- reset mid-run (any state): next cycle IDLE with all outputs 0; no partial enable pulses after reset.

Test Plan:
1. Reset then idle, start=0 for 20 cycles -> state_number=0, busy=0, done=0, mux_enable=0 constant.
2. Defaults, start pulse at t held high -> state_number=1 for exactly 10 cycles, INIT_ARK at t+11 with round_key_idx=10; done at t+78; exactly 40 mux_enable pulses.
3. Round-key order -> round_key_idx on AddRoundKey strobes reads 10,9,8,...,1,0 (11 values).
4. InvMixColumns phase -> imc_word_sel 0,1,2,3 with imc_word_en=1 on each, mux_enable only on word 3, mux_sel=3; occurs 9 times.
5. Handshake -> start held 5 cycles past done: done stays 1, state_number=11; start=0 -> next cycle state_number=0, done=0; start again -> new run with identical timing.
6. Reset asserted in round 5 during R_IMC word 2 -> next cycle all outputs 0, state IDLE; a following start gives a full normal run.
